// File: rtl/conv_pkg.sv
// conv_pkg: shared state encoding and arithmetic helpers for the streaming 3x3 convolution engine.
package conv_pkg;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    function automatic int weight_index(input int co, input int ci, input int ky, input int kx, input int cin);
        return ((co * cin + ci) * 3 + ky) * 3 + kx;
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        return v > hi ? hi : (v < lo ? lo : v);
    endfunction

    function automatic int min_acc_width(input int dw, input int cin);
        return 2 * dw + $clog2(9 * cin) + 1;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: two row memories plus two registered window columns and the live column;
// taps outside the frame read as zero.
module conv_line_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int CIN        = 2,
    parameter int WIDTH      = 16,
    parameter int RW         = 5,
    parameter int CW         = $clog2(WIDTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      step,
    input  logic [RW-1:0]             row,
    input  logic [CW-1:0]             col,
    input  logic [CIN*DATA_WIDTH-1:0] pix,
    output logic [CIN*DATA_WIDTH-1:0] win [3][3]
);
    localparam int PW = CIN * DATA_WIDTH;
    localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;

    logic [PW-1:0] lb0 [WIDTH];
    logic [PW-1:0] lb1 [WIDTH];
    logic [PW-1:0] col_a [3];
    logic [PW-1:0] col_b [3];
    logic [PW-1:0] col_n [3];
    logic          in_col;
    logic [IW-1:0] idx;

    assign in_col   = col < CW'(WIDTH);
    assign idx      = in_col ? col[IW-1:0] : '0;
    // lb0 holds row r-1 and lb1 row r-2; both are outside the frame for the first scan rows
    assign col_n[0] = in_col && row > RW'(1) ? lb1[idx] : '0;
    assign col_n[1] = in_col && row > RW'(0) ? lb0[idx] : '0;
    assign col_n[2] = pix;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                lb0[i] <= '0;
                lb1[i] <= '0;
            end
            for (int k = 0; k < 3; k++) begin
                col_a[k] <= '0;
                col_b[k] <= '0;
            end
        end else if (step) begin
            if (in_col) begin
                lb1[idx] <= lb0[idx];
                lb0[idx] <= pix;
            end
            for (int k = 0; k < 3; k++) begin
                col_a[k] <= col == '0 ? '0 : col_b[k];
                col_b[k] <= col_n[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            win[k][0] = col_a[k];
            win[k][1] = col_b[k];
            win[k][2] = col_n[k];
        end
    end

endmodule

// File: rtl/stream_conv3x3_engine.sv
// stream_conv3x3_engine: line-buffered 3x3 convolution with zero padding, run-time stride/ReLU,
// shift-and-saturate quantisation and a single backpressured output register.
module stream_conv3x3_engine
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CIN        = 2,
    parameter int COUT       = 2,
    parameter int HEIGHT     = 16,
    parameter int WIDTH      = 16,
    parameter int ACC_WIDTH  = 24,
    parameter int SHIFT      = 0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   cfg_stride2,
    input  logic                                   cfg_relu,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   sat_flag,
    input  logic                                   w_wr_en,
    input  logic [$clog2(COUT*CIN*9)-1:0]          w_addr,
    input  logic [DATA_WIDTH-1:0]                  w_data,
    input  logic                                   b_wr_en,
    input  logic [(COUT > 1 ? $clog2(COUT) : 1)-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0]                  b_data,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [CIN*DATA_WIDTH-1:0]              in_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [COUT*DATA_WIDTH-1:0]             out_data
);
    localparam int NW = COUT * CIN * 9;
    localparam int PW = CIN * DATA_WIDTH;
    localparam int RW = $clog2(HEIGHT + 2);
    localparam int CW = $clog2(WIDTH + 1);

    if (ACC_WIDTH < min_acc_width(DATA_WIDTH, CIN)) begin : g_acc_chk
        $error("ACC_WIDTH too narrow for full-precision accumulation");
    end
    if (HEIGHT % 2 != 0 || WIDTH % 2 != 0) begin : g_dim_chk
        $error("HEIGHT and WIDTH must be even");
    end

    state_t                        state_q, state_d;
    logic [RW-1:0]                 r_q;
    logic [CW-1:0]                 c_q;
    logic                          stride2_q, relu_q;
    logic signed [DATA_WIDTH-1:0]  w_mem [NW];
    logic signed [DATA_WIDTH-1:0]  b_mem [COUT];
    logic [PW-1:0]                 win [3][3];
    logic                          in_pos, stall, step, last, emit;
    logic signed [ACC_WIDTH-1:0]   acc, y;
    logic signed [63:0]            y_ext, y_sat;
    logic [COUT*DATA_WIDTH-1:0]    res;
    logic                          res_sat;

    assign in_pos   = r_q < RW'(HEIGHT) && c_q < CW'(WIDTH);
    assign stall    = out_valid && !out_ready;
    assign in_ready = state_q == S_RUN && in_pos && !stall;
    assign step     = state_q == S_RUN && !stall && (!in_pos || in_valid);
    assign last     = r_q == RW'(HEIGHT) && c_q == CW'(WIDTH);
    // centre (r-1, c-1) is in frame once r, c >= 1; stride 2 keeps even centres, i.e. odd r and c
    assign emit     = r_q != '0 && c_q != '0 && (!stride2_q || (r_q[0] && c_q[0]));
    assign busy     = state_q != S_IDLE;
    assign done     = state_q == S_DONE;

    conv_line_buffer #(
        .DATA_WIDTH(DATA_WIDTH),
        .CIN       (CIN),
        .WIDTH     (WIDTH),
        .RW        (RW),
        .CW        (CW)
    ) u_line_buffer (
        .clk (clk),
        .rst (rst),
        .step(step),
        .row (r_q),
        .col (c_q),
        .pix (in_pos ? in_data : '0),
        .win (win)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = start ? S_RUN : S_IDLE;
            S_RUN:   state_d = step && last ? S_FLUSH : S_RUN;
            S_FLUSH: state_d = out_valid ? S_FLUSH : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        res     = '0;
        res_sat = 1'b0;
        acc     = '0;
        y       = '0;
        y_ext   = '0;
        y_sat   = '0;
        for (int co = 0; co < COUT; co++) begin
            acc = ACC_WIDTH'(b_mem[co]) <<< SHIFT;
            for (int ci = 0; ci < CIN; ci++)
                for (int ky = 0; ky < 3; ky++)
                    for (int kx = 0; kx < 3; kx++)
                        acc = acc + ACC_WIDTH'(w_mem[weight_index(co, ci, ky, kx, CIN)])
                                  * ACC_WIDTH'($signed(win[ky][kx][ci*DATA_WIDTH +: DATA_WIDTH]));
            y     = acc >>> SHIFT;
            y     = relu_q && y[ACC_WIDTH-1] ? '0 : y;
            y_ext = 64'(y);
            y_sat = saturate(y_ext, DATA_WIDTH);
            res[co*DATA_WIDTH +: DATA_WIDTH] = y_sat[DATA_WIDTH-1:0];
            res_sat = res_sat | (y_sat != y_ext);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            r_q       <= '0;
            c_q       <= '0;
            stride2_q <= 1'b0;
            relu_q    <= 1'b0;
            sat_flag  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start) begin
                r_q       <= '0;
                c_q       <= '0;
                stride2_q <= cfg_stride2;
                relu_q    <= cfg_relu;
                sat_flag  <= 1'b0;
            end else if (step) begin
                c_q <= c_q == CW'(WIDTH) ? '0 : c_q + 1'b1;
                r_q <= c_q == CW'(WIDTH) ? r_q + 1'b1 : r_q;
            end
            if (step && emit) begin
                out_valid <= 1'b1;
                out_data  <= res;
                if (res_sat) sat_flag <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NW; i++) w_mem[i] <= '0;
            for (int i = 0; i < COUT; i++) b_mem[i] <= '0;
        end else if (state_q == S_IDLE) begin
            if (w_wr_en && int'(w_addr) < NW) w_mem[w_addr] <= w_data;
            if (b_wr_en && int'(b_addr) < COUT) b_mem[b_addr] <= b_data;
        end
    end

endmodule

// File: doc/stream_conv3x3_engine.md
Name: stream_conv3x3_engine

Overview:
- Streaming 3x3 convolution engine with zero padding of 1.
- Input is one pixel per handshake, raster order, with CIN channels packed per pixel. Output is one pixel per handshake with COUT channels packed per pixel.
- Stride (1 or 2) and ReLU are selected at run time. Weights and biases load through a write port. Results are quantised with an arithmetic shift and signed saturation.
- Replaces the fixed, fully-combinational conv stages inside the contextual encoder/decoder chain with a line-buffered, backpressure-aware building block.

Parameters:
- DATA_WIDTH, 8: signed activation/weight/bias width.
- CIN, 2: input channels per pixel.
- COUT, 2: output channels per pixel.
- HEIGHT, 16: frame rows; must be even.
- WIDTH, 16: frame columns; must be even.
- ACC_WIDTH, 24: signed accumulator width; must be >= 2*DATA_WIDTH + clog2(9*CIN) + 1 (elaboration check).
- SHIFT, 0: arithmetic right shift applied before saturation.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-low.
- start, in, 1: frame start pulse; latches cfg_*.
- cfg_stride2, in, 1: 1 = stride 2, 0 = stride 1.
- cfg_relu, in, 1: clamp negative results to 0.
- busy, out, 1: frame in progress.
- done, out, 1: one-cycle pulse at frame end.
- sat_flag, out, 1: sticky; any output saturated this frame.
- w_wr_en, in, 1: weight write strobe.
- w_addr, in, clog2(COUT*CIN*9): weight index, ((co*CIN+ci)*3+ky)*3+kx.
- w_data, in, DATA_WIDTH: signed weight.
- b_wr_en, in, 1: bias write strobe.
- b_addr, in, clog2(COUT) (min 1): output channel.
- b_data, in, DATA_WIDTH: signed bias.
- in_valid / in_ready, in / out, 1 each: input handshake.
- in_data, in, CIN*DATA_WIDTH: channel ci at bits [ci*DATA_WIDTH +: DATA_WIDTH].
- out_valid / out_ready, out / in, 1 each: output handshake.
- out_data, out, COUT*DATA_WIDTH: same channel packing as in_data.

Behaviour:
- Reset (rst low, asynchronous) clears:
  - all outputs to 0 and the FSM to IDLE;
  - line buffers, weights and biases to 0.
- Reset asserted mid-frame aborts the frame; no done pulse is produced.
- FSM IDLE -> RUN -> FLUSH -> DONE -> IDLE:
  - IDLE: in_ready = 0. start moves to RUN and latches cfg, clears sat_flag, zeroes counters. Weight/bias writes are accepted only in IDLE; writes in any other state are ignored.
  - RUN: the internal scan position (r, c) runs over rows 0..HEIGHT and columns 0..WIDTH.
    - Positions with r < HEIGHT and c < WIDTH consume one input beat each; in_ready = 1 only there, and only when not stalled.
    - Column WIDTH of every row, and all of row HEIGHT, are injected zero pixels (one per cycle, no input consumed).
    - After position (HEIGHT, WIDTH) the FSM enters FLUSH.
  - FLUSH: waits until the output register drains, then enters DONE.
  - DONE: done = 1 for exactly one cycle, then IDLE.
- Window: processing scan position (r, c) completes the 3x3 window centred at (r-1, c-1). Out-of-frame taps (row -1, column -1, row HEIGHT, column WIDTH) read 0.
- Emission: the centre (R, C) produces an output only if:
  - 0 <= R < HEIGHT and 0 <= C < WIDTH, and
  - with stride 2, additionally R and C are both even.
- Output count per frame: HEIGHT*WIDTH (stride 1) or HEIGHT*WIDTH/4 (stride 2), in raster order.
- Arithmetic, per co:
  - acc = sum over ci, ky, kx of w*x (signed, full precision, ACC_WIDTH), plus bias sign-extended and shifted left by SHIFT;
  - y = acc >>> SHIFT;
  - if cfg_relu and y < 0, y = 0;
  - saturate y to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. If saturation occurs, sat_flag is set.
- Latency: out_valid rises 1 cycle after the scan step that completes the window (single output register).
- Backpressure: out_valid holds and out_data stays stable until out_ready. While out_valid && !out_ready and the current step would emit, the scan stalls (in_ready = 0, no injection). Non-emitting steps also stall when the output register is full.
- Simultaneous events:
  - out handshake and a new emit in the same cycle: the register reloads with no bubble;
  - start while busy: ignored;
  - in_valid while in_ready = 0: data is not consumed.

Decomposition:
- Package conv_pkg holds:
  - the FSM state enum;
  - a weight-index function;
  - a saturate function;
  - the ACC_WIDTH minimum-width constant function.
- Sub-module conv_line_buffer holds two WIDTH-deep line memories (CIN*DATA_WIDTH wide) plus the 3x3 window shift registers, with zero-tap insertion at frame borders. The MAC/quantise logic and FSM stay in the top.

Test Plan:
- CIN=2, COUT=2, weights all 1, bias 0, stride 1, input all 1 -> 256 outputs: corners 8, edges 12, interior 18; done once; sat_flag 0.
- Same data, stride 2 -> 64 outputs: (0,0) = 8, row 0 / column 0 = 12, others 18.
- Input all 127, weights all 127 -> every output 127 and sat_flag = 1. Repeat with weights all -1 and cfg_relu = 1 -> every output 0.
- Random out_ready (50%) and random in_valid gaps -> output stream identical to the no-stall run; out_data never changes while out_valid && !out_ready.
- Assert rst mid-frame (after 100 inputs), then write new weights and start again -> no done from the aborted frame; second frame correct.
- Weight write during RUN, and start during RUN -> both ignored; results match the pre-loaded weights.
